// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R1W register file with write-first bypass and a per-register busy scoreboard
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module regfile_scoreboard #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  issue,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   busy_count
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [ADDR_WIDTH:0] busy_count_q, busy_count_d;
  logic z1, z2, zi, zw, hit1, hit2, hiti;
  always_comb begin
    z1 = ZERO_REG && rs1 == '0;
    z2 = ZERO_REG && rs2 == '0;
    zi = ZERO_REG && issue_rd == '0;
    zw = ZERO_REG && rd == '0;
    hit1 = wr && rd == rs1;
    hit2 = wr && rd == rs2;
    hiti = wr && rd == issue_rd;
    rd1 = z1 ? '0 : hit1 ? wd : regs_q[rs1];
    rd2 = z2 ? '0 : hit2 ? wd : regs_q[rs2];
    busy1 = !z1 && busy_q[rs1] && !hit1;
    busy2 = !z2 && busy_q[rs2] && !hit2;
    stall = issue && (busy1 || busy2 || (busy_q[issue_rd] && !hiti));
    busy_count = busy_count_q;
  end
  // writeback clears first so a same-edge accepted issue to the same index leaves it set
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr && !zw) regs_d[rd] = wd;
    if (wr) busy_d[rd] = 1'b0;
    if (issue && !stall && !zi) busy_d[issue_rd] = 1'b1;
    busy_count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) busy_count_d = busy_count_d + (ADDR_WIDTH+1)'(busy_d[i]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vector table plus hand sequences for reset corner cases
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd, issue_rd;
  logic [31:0] rd1, rd2, wd;
  logic wr, issue, busy1, busy2, stall;
  logic [5:0] busy_count;
  int n_checks = 0;
  int n_fail = 0;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
    .wr(wr), .rd(rd), .wd(wd), .issue(issue), .issue_rd(issue_rd),
    .busy1(busy1), .busy2(busy2), .stall(stall), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
    logic        est;
    logic [5:0]  ecnt;
  } vec_t;

  vec_t v [19];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic i, input logic [4:0] ia, input logic [4:0] s1, input logic [4:0] s2);
    wr = w; rd = a; wd = d; issue = i; issue_rd = ia; rs1 = s1; rs2 = s2;
  endtask

  initial begin
    v[0]  = '{1, 6, 32'hAAAAAAAA, 0, 0, 6, 0, 32'hAAAAAAAA, 32'h0,        0, 0, 0, 0};
    v[1]  = '{1, 3, 32'h55555555, 0, 0, 6, 3, 32'hAAAAAAAA, 32'h55555555, 0, 0, 0, 0};
    v[2]  = '{0, 0, 32'h0,        0, 0, 6, 3, 32'hAAAAAAAA, 32'h55555555, 0, 0, 0, 0};
    v[3]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0, 6, 32'h0,        32'hAAAAAAAA, 0, 0, 0, 0};
    v[4]  = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0};
    v[5]  = '{1, 7, 32'h11111111, 0, 0, 7, 3, 32'h11111111, 32'h55555555, 0, 0, 0, 0};
    v[6]  = '{1, 7, 32'h12345678, 0, 0, 7, 7, 32'h12345678, 32'h12345678, 0, 0, 0, 0};
    v[7]  = '{0, 0, 32'h0,        1, 5, 7, 6, 32'h12345678, 32'hAAAAAAAA, 0, 0, 0, 1};
    v[8]  = '{0, 0, 32'h0,        1, 8, 5, 0, 32'h0,        32'h0,        1, 0, 1, 1};
    v[9]  = '{1, 5, 32'hCAFEBABE, 0, 0, 5, 3, 32'hCAFEBABE, 32'h55555555, 0, 0, 0, 0};
    v[10] = '{0, 0, 32'h0,        1, 9, 5, 9, 32'hCAFEBABE, 32'h0,        0, 0, 0, 1};
    v[11] = '{0, 0, 32'h0,        1, 9, 0, 0, 32'h0,        32'h0,        0, 0, 1, 1};
    v[12] = '{1, 9, 32'hDEADBEEF, 1, 9, 9, 9, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 1};
    v[13] = '{0, 0, 32'h0,        0, 0, 9, 7, 32'hDEADBEEF, 32'h12345678, 1, 0, 0, 1};
    v[14] = '{0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1};
    v[15] = '{1, 9, 32'h00000001, 1, 4, 4, 9, 32'h0,        32'h00000001, 0, 0, 0, 1};
    v[16] = '{1, 4, 32'h44444444, 1, 2, 4, 2, 32'h44444444, 32'h0,        0, 0, 0, 1};
    v[17] = '{0, 0, 32'h0,        1, 3, 2, 1, 32'h0,        32'h0,        1, 0, 1, 1};
    v[18] = '{1, 2, 32'h22222222, 0, 0, 2, 2, 32'h22222222, 32'h22222222, 0, 0, 0, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 6, 3);
    #12;
    check("reset_rd1", rd1, 0);
    check("reset_rd2", rd2, 0);
    check("reset_cnt", busy_count, 0);
    check("reset_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 19; k++) begin
      drive(v[k].wr, v[k].rd, v[k].wd, v[k].iss, v[k].ird, v[k].rs1, v[k].rs2);
      #1;
      check($sformatf("v%0d_rd1", k), rd1, v[k].e1);
      check($sformatf("v%0d_rd2", k), rd2, v[k].e2);
      check($sformatf("v%0d_busy1", k), busy1, v[k].eb1);
      check($sformatf("v%0d_busy2", k), busy2, v[k].eb2);
      check($sformatf("v%0d_stall", k), stall, v[k].est);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cnt", k), busy_count, v[k].ecnt);
      @(negedge clk);
    end

    for (int k = 1; k <= 4; k++) begin
      drive(1, 5'(k), 32'h100 + k, 0, 0, 0, 0);
      @(negedge clk);
    end
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 1, 5'(k), 0, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 1, 4);
    #1;
    check("seq_cnt4", busy_count, 4);
    check("seq_rd1", rd1, 32'h101);
    check("seq_rd2", rd2, 32'h104);
    check("seq_busy1", busy1, 1);
    drive(1, 7, 32'h77, 1, 1, 1, 2);
    #1;
    check("seq_stall_pre", stall, 1);
    rst = 1'b1;
    #1;
    check("arst_rd1", rd1, 0);
    check("arst_rd2", rd2, 0);
    check("arst_cnt", busy_count, 0);
    check("arst_stall", stall, 0);
    check("arst_busy1", busy1, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 7, 1);
    rst = 1'b0;
    #1;
    check("post_rst_r7", rd1, 0);
    check("post_rst_cnt", busy_count, 0);
    drive(1, 7, 32'h77, 0, 0, 7, 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 7, 1);
    #1;
    check("post_rst_wr", rd1, 32'h77);
    check("post_rst_r1", rd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
